// File: rtl/maze_env_responder.sv
// Environment side of the Q-learning maze exchange: owns the 5x5 grid, applies
// one agent action per handshake and returns next state, reward and episode flags.
module maze_env_responder #(
    parameter int unsigned        MAX_STEPS   = 64,
    parameter int unsigned        START_STATE = 1,
    parameter int unsigned        GOAL_STATE  = 25,
    parameter logic signed [15:0] R_GOAL      = 16'sd100,
    parameter logic signed [15:0] R_TRAP      = -16'sd100,
    parameter logic signed [15:0] R_STEP      = -16'sd1,
    parameter logic signed [15:0] R_WALL      = -16'sd5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               act_valid,
    input  logic [3:0]         act,
    output logic               act_ready,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [5:0]         next_state,
    output logic signed [15:0] next_reward,
    output logic               goal,
    output logic               error,
    output logic               done,
    output logic [5:0]         current_state,
    output logic [7:0]         step_cnt,
    output logic [15:0]        episode_cnt
);

    localparam logic [5:0] START_S = 6'(START_STATE);
    localparam logic [5:0] GOAL_S  = 6'(GOAL_STATE);
    localparam logic [7:0] MAX_S   = 8'(MAX_STEPS);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP,
        RESTART
    } state_e;

    function automatic logic is_trap(input logic [5:0] s);
        case (s)
            6'd3, 6'd4, 6'd7, 6'd13, 6'd14, 6'd17, 6'd19, 6'd22: is_trap = 1'b1;
            default:                                             is_trap = 1'b0;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         act_q, act_d;
    logic [5:0]         cur_q, cur_d;
    logic [5:0]         nxt_q, nxt_d;
    logic signed [15:0] reward_q, reward_d;
    logic               goal_q, goal_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic [7:0]         step_q, step_d;
    logic [15:0]        epi_q, epi_d;

    logic [4:0] idx;
    logic [4:0] row_base;
    logic [2:0] row;
    logic [2:0] col;
    logic       legal_act;
    logic       off_grid;
    logic [5:0] target;
    logic [5:0] landing;
    logic [7:0] step_inc;

    // Decode the registered position into grid coordinates (s = 5*row + col + 1).
    always_comb begin
        idx = 5'(cur_q - 6'd1);
        if (idx >= 5'd20)      row = 3'd4;
        else if (idx >= 5'd15) row = 3'd3;
        else if (idx >= 5'd10) row = 3'd2;
        else if (idx >= 5'd5)  row = 3'd1;
        else                   row = 3'd0;
        row_base = 5'd5 * {2'b00, row};
        col      = 3'(idx - row_base);
    end

    always_comb begin
        legal_act = 1'b1;
        off_grid  = 1'b0;
        target    = cur_q;
        case (act_q)
            4'b0001: begin off_grid = (row == 3'd0); target = cur_q - 6'd5; end
            4'b0010: begin off_grid = (row == 3'd4); target = cur_q + 6'd5; end
            4'b0100: begin off_grid = (col == 3'd0); target = cur_q - 6'd1; end
            4'b1000: begin off_grid = (col == 3'd4); target = cur_q + 6'd1; end
            default: legal_act = 1'b0;
        endcase
        landing  = (legal_act && !off_grid) ? target : cur_q;
        step_inc = (step_q == 8'hFF) ? step_q : step_q + 8'd1;
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d    = state_q;
        act_d      = act_q;
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        reward_d   = reward_q;
        goal_d     = goal_q;
        err_d      = err_q;
        done_d     = done_q;
        step_d     = step_q;
        epi_d      = epi_q;
        act_ready  = 1'b0;
        resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by rst_n so the agent never sees ready while reset is held.
                act_ready = en & rst_n;
                if (act_valid && act_ready) begin
                    act_d   = act;
                    state_d = CALC;
                end
            end
            CALC: begin
                nxt_d  = landing;
                cur_d  = landing;
                goal_d = (landing == GOAL_S);
                err_d  = is_trap(landing);
                if (!legal_act || off_grid) reward_d = R_WALL;
                else if (landing == GOAL_S)  reward_d = R_GOAL;
                else if (is_trap(landing))   reward_d = R_TRAP;
                else                         reward_d = R_STEP;
                done_d  = (landing == GOAL_S) || is_trap(landing) || (step_inc == MAX_S);
                step_d  = step_inc;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = done_q ? RESTART : IDLE;
            end
            RESTART: begin
                cur_d   = START_S;
                step_d  = 8'd0;
                epi_d   = epi_q + 16'd1;
                goal_d  = 1'b0;
                err_d   = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            act_q    <= 4'b0000;
            cur_q    <= START_S;
            nxt_q    <= START_S;
            reward_q <= 16'sd0;
            goal_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            step_q   <= 8'd0;
            epi_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            cur_q    <= cur_d;
            nxt_q    <= nxt_d;
            reward_q <= reward_d;
            goal_q   <= goal_d;
            err_q    <= err_d;
            done_q   <= done_d;
            step_q   <= step_d;
            epi_q    <= epi_d;
        end
    end

    assign next_state    = nxt_q;
    assign next_reward   = reward_q;
    assign goal          = goal_q;
    assign error         = err_q;
    assign done          = done_q;
    assign current_state = cur_q;
    assign step_cnt      = step_q;
    assign episode_cnt   = epi_q;

endmodule

// File: tb/tb_maze_env_responder.sv
// Directed bench for maze_env_responder: three instances (default, 4-step limit,
// start at state 10) share clock and reset; expected values are hand-computed.
module tb_maze_env_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               en         [3];
    logic               act_valid  [3];
    logic [3:0]         act        [3];
    logic               resp_ready [3];
    logic               act_ready  [3];
    logic               resp_valid [3];
    logic [5:0]         next_state [3];
    logic signed [15:0] next_reward[3];
    logic               goal       [3];
    logic               error      [3];
    logic               done       [3];
    logic [5:0]         current_state[3];
    logic [7:0]         step_cnt   [3];
    logic [15:0]        episode_cnt[3];

    maze_env_responder u0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .act_valid(act_valid[0]), .act(act[0]),
        .act_ready(act_ready[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .next_state(next_state[0]), .next_reward(next_reward[0]), .goal(goal[0]),
        .error(error[0]), .done(done[0]), .current_state(current_state[0]),
        .step_cnt(step_cnt[0]), .episode_cnt(episode_cnt[0]));

    maze_env_responder #(.MAX_STEPS(4)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .act_valid(act_valid[1]), .act(act[1]),
        .act_ready(act_ready[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .next_state(next_state[1]), .next_reward(next_reward[1]), .goal(goal[1]),
        .error(error[1]), .done(done[1]), .current_state(current_state[1]),
        .step_cnt(step_cnt[1]), .episode_cnt(episode_cnt[1]));

    maze_env_responder #(.START_STATE(10)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .act_valid(act_valid[2]), .act(act[2]),
        .act_ready(act_ready[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .next_state(next_state[2]), .next_reward(next_reward[2]), .goal(goal[2]),
        .error(error[2]), .done(done[2]), .current_state(current_state[2]),
        .step_cnt(step_cnt[2]), .episode_cnt(episode_cnt[2]));

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0]         r_state;
    logic signed [15:0] r_reward;
    logic               r_goal, r_err, r_done;
    logic [7:0]         r_step;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one action on unit u, capture the response, optionally stall the
    // response for `hold` cycles, and return at the negedge after it is accepted.
    task automatic do_step(input int u, input logic [3:0] a, input int hold);
        int n;
        @(negedge clk);
        resp_ready[u] = (hold == 0);
        act_valid[u]  = 1'b1;
        act[u]        = a;
        n = 0;
        while (!act_ready[u] && n < 20) begin @(negedge clk); n++; end
        check("accept_ready", act_ready[u], 1);
        @(negedge clk);
        act_valid[u] = 1'b0;
        act[u]       = 4'b0000;
        check("calc_ready_low", act_ready[u], 0);
        check("calc_valid_low", resp_valid[u], 0);
        @(negedge clk);
        n = 0;
        while (!resp_valid[u] && n < 20) begin @(negedge clk); n++; end
        check("resp_valid", resp_valid[u], 1);
        r_state  = next_state[u];
        r_reward = next_reward[u];
        r_goal   = goal[u];
        r_err    = error[u];
        r_done   = done[u];
        r_step   = step_cnt[u];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", resp_valid[u], 1);
            check("hold_ready", act_ready[u], 0);
            check("hold_state", next_state[u], r_state);
            check("hold_reward", next_reward[u], r_reward);
            check("hold_done", done[u], r_done);
        end
        resp_ready[u] = 1'b1;
        @(negedge clk);
    endtask

    task automatic expect_resp(input string tag, input int st, input int rw,
                               input int g, input int e, input int d, input int sc);
        check({tag, ".state"},  r_state,  st);
        check({tag, ".reward"}, r_reward, rw);
        check({tag, ".goal"},   r_goal,   g);
        check({tag, ".error"},  r_err,    e);
        check({tag, ".done"},   r_done,   d);
        check({tag, ".steps"},  r_step,   sc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b1; act_valid[i] = 1'b0; act[i] = 4'b0000; resp_ready[i] = 1'b1;
        end
        #2;
        check("rst_act_ready", act_ready[0], 0);
        check("rst_resp_valid", resp_valid[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_cur", current_state[0], 1);
        check("init_next", next_state[0], 1);
        check("init_reward", next_reward[0], 0);
        check("init_steps", step_cnt[0], 0);
        check("init_episodes", episode_cnt[0], 0);
        check("init_ready", act_ready[0], 1);
        check("init_done", done[0], 0);
        check("init_cur_u2", current_state[2], 10);

        // Reset asserted while a response is pending: nothing survives it.
        @(negedge clk);
        resp_ready[1] = 1'b0; act_valid[1] = 1'b1; act[1] = 4'b1000;
        @(negedge clk);
        act_valid[1] = 1'b0;
        @(negedge clk);
        check("mid_valid", resp_valid[1], 1);
        check("mid_next", next_state[1], 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", resp_valid[1], 0);
        check("mid_rst_cur", current_state[1], 1);
        check("mid_rst_next", next_state[1], 1);
        check("mid_rst_steps", step_cnt[1], 0);
        check("mid_rst_episodes", episode_cnt[1], 0);
        check("mid_rst_ready", act_ready[1], 0);
        @(negedge clk);
        rst_n = 1'b1; resp_ready[1] = 1'b1;
        #1;
        check("post_rst_ready", act_ready[1], 1);

        // Moves, walls and illegal codes, then a trap.
        do_step(0, 4'b1000, 0); expect_resp("right1", 2, -1, 0, 0, 0, 1);
        do_step(0, 4'b0100, 0); expect_resp("left2", 1, -1, 0, 0, 0, 2);
        do_step(0, 4'b0001, 0); expect_resp("wall_up", 1, -5, 0, 0, 0, 3);
        do_step(0, 4'b0000, 0); expect_resp("act_zero", 1, -5, 0, 0, 0, 4);
        do_step(0, 4'b0011, 0); expect_resp("act_multi", 1, -5, 0, 0, 0, 5);
        do_step(0, 4'b1000, 0); expect_resp("right6", 2, -1, 0, 0, 0, 6);
        do_step(0, 4'b1000, 0); expect_resp("trap", 3, -100, 0, 1, 1, 7);
        check("restart_ready", act_ready[0], 0);
        check("restart_pre_cur", current_state[0], 3);
        @(negedge clk);
        check("trap_cur", current_state[0], 1);
        check("trap_episodes", episode_cnt[0], 1);
        check("trap_steps", step_cnt[0], 0);
        check("trap_done_clr", done[0], 0);
        check("trap_ready", act_ready[0], 1);

        // Response stalled for 10 cycles, then enable low in IDLE.
        do_step(0, 4'b0010, 10); expect_resp("stall_down", 6, -1, 0, 0, 0, 1);
        @(negedge clk);
        en[0] = 1'b0; act_valid[0] = 1'b1; act[0] = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("en_low_ready", act_ready[0], 0);
            check("en_low_valid", resp_valid[0], 0);
            check("en_low_cur", current_state[0], 6);
        end
        act_valid[0] = 1'b0; en[0] = 1'b1;

        // Goal path on the instance starting at 10.
        do_step(2, 4'b1000, 0); expect_resp("wall_right", 10, -5, 0, 0, 0, 1);
        do_step(2, 4'b0010, 0); expect_resp("down15", 15, -1, 0, 0, 0, 2);
        do_step(2, 4'b0010, 0); expect_resp("down20", 20, -1, 0, 0, 0, 3);
        do_step(2, 4'b0010, 0); expect_resp("goal", 25, 100, 1, 0, 1, 4);
        @(negedge clk);
        check("goal_episodes", episode_cnt[2], 1);
        check("goal_cur", current_state[2], 10);
        check("goal_flag_clr", goal[2], 0);

        // Step limit of 4 on a legal shuttle between 1 and 2.
        do_step(1, 4'b1000, 0); expect_resp("lim1", 2, -1, 0, 0, 0, 1);
        do_step(1, 4'b0100, 0); expect_resp("lim2", 1, -1, 0, 0, 0, 2);
        do_step(1, 4'b1000, 0); expect_resp("lim3", 2, -1, 0, 0, 0, 3);
        do_step(1, 4'b0100, 0); expect_resp("lim4", 1, -1, 0, 0, 1, 4);
        @(negedge clk);
        check("lim_episodes", episode_cnt[1], 1);
        check("lim_steps", step_cnt[1], 0);
        check("lim_cur", current_state[1], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/maze_env_responder.md
# maze_env_responder

Environment-side responder for the Q-learning maze. The agent issues one action per step; this block owns the 5x5 maze, applies the move, and returns the next state, a signed reward and the goal/error/done flags. It also restarts episodes and counts them. It is the environment end of the agent's action/response exchange: it answers agent action requests rather than issuing them.

## Interface
- MAX_STEPS, 64: step limit per episode (1..255); reaching it ends the episode.
- START_STATE, 1: state loaded on reset and on episode restart.
- GOAL_STATE, 25: terminal success state.
- R_GOAL, 100: reward for entering GOAL_STATE (16-bit signed).
- R_TRAP, -100: reward for entering a trap state.
- R_STEP, -1: reward for a legal non-terminal move.
- R_WALL, -5: reward for an off-grid move or an illegal action code.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable; low blocks new action acceptance only.
- act_valid  in  1  agent presents an action.
- act  in  4  one-hot action: bit0 up, bit1 down, bit2 left, bit3 right.
- act_ready  out  1  responder can accept an action.
- resp_valid  out  1  response fields valid.
- resp_ready  in  1  agent accepts the response.
- next_state  out  6  state after the move, 1..25.
- next_reward  out  16  signed reward for the move.
- goal  out  1  next_state == GOAL_STATE.
- error  out  1  next_state is a trap: 3, 4, 7, 13, 14, 17, 19 or 22.
- done  out  1  the episode ended with this response: goal, error, or step limit.
- current_state  out  6  registered agent position.
- step_cnt  out  8  steps taken in the current episode.
- episode_cnt  out  16  completed episodes, wraps at 0xFFFF -> 0.

## Operation
- Grid mapping: s = 5*row + col + 1; row 0 is the top row.
- Up is row-1, down is row+1, left is col-1, right is col+1.
- FSM states: IDLE, CALC, RESP, RESTART.
- IDLE:
  - act_ready = en.
  - When act_valid & act_ready: latch act, go to CALC.
- CALC (1 cycle): compute the move and register the response fields.
  - If act is not exactly one-hot (0000 or multiple bits set): stay in place, reward R_WALL.
  - If the move leaves the grid: stay in place, reward R_WALL.
  - Otherwise move to the target.
    - Target == GOAL_STATE: reward R_GOAL.
    - Target is a trap: reward R_TRAP.
    - Otherwise: reward R_STEP.
  - The goal and trap rewards take priority over the step limit.
  - step_cnt increments, saturating at 255.
  - done = goal | error | (step_cnt_new == MAX_STEPS).
  - current_state <= next_state.
  - Go to RESP.
- RESP:
  - resp_valid = 1; all response fields are held stable until resp_ready.
  - On resp_valid & resp_ready: go to RESTART if done, else IDLE.
- RESTART (1 cycle):
  - current_state <= START_STATE, step_cnt <= 0, episode_cnt increments.
  - Go to IDLE.
- en low:
  - In IDLE, act_ready = 0.
  - CALC, RESP and RESTART complete normally.
- Flags goal, error and done are registered with the response. They are cleared in CALC for non-terminal results and in RESTART.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - FSM = IDLE.
  - current_state = next_state = START_STATE.
  - next_reward = 0; step_cnt = 0; episode_cnt = 0.
  - resp_valid, goal, error and done = 0.
  - act_ready = 0 while rst_n is low; after release it follows en.
- Latency:
  - Action accepted at edge N.
  - Response registered at edge N+1; resp_valid is high during the cycle after N+1.
  - Earliest response accept is edge N+2.
  - Back-to-back throughput: one action per 3 cycles (IDLE, CALC, RESP); add 1 cycle after a done response.
- act_ready is low in CALC, RESP and RESTART. An act_valid held during those states is not consumed.
- act must be stable only on the accepting edge.
- Reset asserted mid-CALC or mid-RESP: the response is discarded, resp_valid drops immediately, and no episode is counted.
- A step-limit end with a legal move gives reward R_STEP with done = 1, goal = 0, error = 0.

## Test plan
- Reset, then right from state 1:
  - After reset: current_state = 1, act_ready = 1.
  - act = 1000 -> next_state 2, reward -1, done 0, step_cnt 1.
- Walls:
  - From state 1, act = 0001 (up) -> next_state 1, reward -5.
  - act = 0000 -> next_state 1, reward -5.
  - act = 0011 -> next_state 1, reward -5.
- Trap: from 2, right -> next_state 3, reward -100, error 1, done 1.
  - After the accept, RESTART: current_state = 1, episode_cnt = 1, step_cnt = 0.
- Goal: drive a trap-free path to 25 (e.g. last step 20 -> down).
  - Final response: next_state 25, reward +100, goal 1, done 1.
  - Then episode_cnt increments.
- Backpressure and enable:
  - Hold resp_ready = 0 for 10 cycles: resp_valid and all fields stay constant; act_ready = 0 throughout.
  - With en = 0 in IDLE and act_valid = 1: no acceptance.
- Step limit, and reset mid-response:
  - MAX_STEPS = 4, alternate left/right between 1 and 2 -> 4th response has done 1, reward -1.
  - rst_n pulsed low while in RESP -> resp_valid drops immediately, current_state = 1, episode_cnt unchanged.
